// File: rtl/td4_clock_ctrl.sv
// rtl/td4_clock_ctrl.sv - TD4 CPU clock-enable generator: slow/fast prescaler edges or debounced STEP button.
// Optional HALT_EN macro adds a same-domain halt input that drops pulses while high.
module td4_clock_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       slow_clk_a,
    input  logic       slow_clk_b,
    input  logic [1:0] mode,
    input  logic       step_btn,
`ifdef HALT_EN
    input  logic       halt,
`endif
    output logic       cpu_clk_en,
    output logic       btn_level,
    output logic [7:0] tick_count
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARM     = 2'd1,
        S_PRESSED = 2'd2,
        S_REL     = 2'd3
    } state_t;

    logic [1:0]       r_a_sync;
    logic [1:0]       r_b_sync;
    logic [1:0]       r_btn_sync;
    logic [1:0]       r_mode_s1;
    logic [1:0]       r_mode_s2;
    logic             r_a_prev;
    logic             r_b_prev;
    logic [2:0]       r_guard;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_btn_level;
    logic             w_btn_level_nxt;
    logic             w_step;

    logic             r_clk_en;
    logic [7:0]       r_tick;

    logic             w_btn;
    logic             w_rise_a;
    logic             w_rise_b;
    logic             w_sel;
    logic             w_halt;
    logic             w_fire;

`ifdef HALT_EN
    assign w_halt = halt;
`else
    assign w_halt = 1'b0;
`endif

    // r_guard fills with ones so edges are ignored until r_*_prev holds post-reset data
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_a_sync   <= 2'b00;
            r_b_sync   <= 2'b00;
            r_btn_sync <= 2'b00;
            r_mode_s1  <= 2'b00;
            r_mode_s2  <= 2'b00;
            r_a_prev   <= 1'b0;
            r_b_prev   <= 1'b0;
            r_guard    <= 3'b000;
        end else begin
            r_a_sync   <= {r_a_sync[0], slow_clk_a};
            r_b_sync   <= {r_b_sync[0], slow_clk_b};
            r_btn_sync <= {r_btn_sync[0], step_btn};
            r_mode_s1  <= mode;
            r_mode_s2  <= r_mode_s1;
            r_a_prev   <= r_a_sync[1];
            r_b_prev   <= r_b_sync[1];
            r_guard    <= {r_guard[1:0], 1'b1};
        end
    end

    assign w_btn    = r_btn_sync[1];
    assign w_rise_a = r_a_sync[1] & ~r_a_prev & r_guard[2];
    assign w_rise_b = r_b_sync[1] & ~r_b_prev & r_guard[2];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_btn_level <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_btn_level <= w_btn_level_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_btn) begin
                    w_state_nxt = S_ARM;
                    w_cnt_nxt   = '0;
                end
            end
            S_ARM: begin
                if (!w_btn)
                    w_state_nxt = S_IDLE;
                else if (r_cnt == C_CNT_MAX)
                    w_state_nxt = S_PRESSED;
                else
                    w_cnt_nxt = r_cnt + 1'b1;
            end
            S_PRESSED: begin
                if (!w_btn) begin
                    w_state_nxt = S_REL;
                    w_cnt_nxt   = '0;
                end
            end
            S_REL: begin
                if (w_btn)
                    w_state_nxt = S_PRESSED;
                else if (r_cnt == C_CNT_MAX)
                    w_state_nxt = S_IDLE;
                else
                    w_cnt_nxt = r_cnt + 1'b1;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // A bounce back to PRESSED from REL keeps the level high and issues no new step
    always_comb begin
        w_step          = 1'b0;
        w_btn_level_nxt = r_btn_level;
        if (r_state == S_ARM && w_btn && r_cnt == C_CNT_MAX) begin
            w_step          = 1'b1;
            w_btn_level_nxt = 1'b1;
        end
        if (r_state == S_REL && !w_btn && r_cnt == C_CNT_MAX)
            w_btn_level_nxt = 1'b0;
    end

    always_comb begin
        w_sel = 1'b0;
        case (r_mode_s2)
            2'b00:   w_sel = w_rise_a;
            2'b01:   w_sel = w_rise_b;
            2'b10:   w_sel = w_step;
            default: w_sel = 1'b0;
        endcase
    end

    assign w_fire = w_sel & ~w_halt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_clk_en <= 1'b0;
            r_tick   <= 8'd0;
        end else begin
            r_clk_en <= w_fire;
            if (w_fire)
                r_tick <= r_tick + 8'd1;
        end
    end

    assign cpu_clk_en = r_clk_en;
    assign btn_level  = r_btn_level;
    assign tick_count = r_tick;

endmodule
